keypad_entry: RTL and testbench



---
 rtl/keypad_entry.sv | 240 ++++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner with debounce; each accepted key shifts a nibble into a 32-bit entry register.
// Optional auto-repeat while a key stays held: define KEYPAD_AUTOREPEAT_EN.
module keypad_entry #(
  parameter int SCAN_DIV       = 150000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        clear,
  output logic [31:0] data,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DB_TARGET = DW'(DEBOUNCE_SCANS);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_TARGET = RW'(REPEAT_SCANS);
`endif

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      col_meta_q, col_s_q;
  logic [CW-1:0]   slot_q, slot_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [3:0]      row_q, row_d;
  logic [1:0]      cand_col_q, cand_col_d;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic [DW-1:0]   rel_cnt_q, rel_cnt_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
`endif

  logic            slot_end_s;
  logic            sample_valid_s;
  logic [1:0]      col_idx_s;
  logic [3:0]      code_s;
  logic            accept_s;
  logic            advance_s;

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'b1111;
      col_s_q    <= 4'b1111;
    end else begin
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
    end
  end

  // State register: FSM state, counters and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      slot_q      <= {CW{1'b0}};
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      cand_col_q  <= 2'd0;
      db_cnt_q    <= {DW{1'b0}};
      rel_cnt_q   <= {DW{1'b0}};
      data_q      <= 32'h0000_0000;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= {RW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      cand_col_q  <= cand_col_d;
      db_cnt_q    <= db_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      data_q      <= data_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  // Slot timing and column sample decode (exactly one low column is a valid sample)
  always_comb begin
    slot_end_s     = (slot_q == SLOT_LAST);
    sample_valid_s = 1'b0;
    col_idx_s      = 2'd0;
    if (slot_end_s) begin
      slot_d = {CW{1'b0}};
    end else begin
      slot_d = slot_q + CW'(1);
    end
    case (col_s_q)
      4'b1110: begin sample_valid_s = 1'b1; col_idx_s = 2'd0; end
      4'b1101: begin sample_valid_s = 1'b1; col_idx_s = 2'd1; end
      4'b1011: begin sample_valid_s = 1'b1; col_idx_s = 2'd2; end
      4'b0111: begin sample_valid_s = 1'b1; col_idx_s = 2'd3; end
      default: begin sample_valid_s = 1'b0; col_idx_s = 2'd0; end
    endcase
    code_s = {row_idx_q, col_idx_s};
  end

  // Next-state logic: every decision is taken only on a slot end
  always_comb begin
    state_d    = state_q;
    cand_col_d = cand_col_q;
    db_cnt_d   = db_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    accept_s   = 1'b0;
    advance_s  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif
    if (slot_end_s) begin
      case (state_q)
        SCAN: begin
          if (sample_valid_s) begin
            cand_col_d = col_idx_s;
            if (DEBOUNCE_SCANS == 1) begin
              accept_s  = 1'b1;
              state_d   = HELD;
              db_cnt_d  = {DW{1'b0}};
              rel_cnt_d = {DW{1'b0}};
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_d = {RW{1'b0}};
`endif
            end else begin
              db_cnt_d = DW'(1);
              state_d  = DEBOUNCE;
            end
          end else begin
            advance_s = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (sample_valid_s && (col_idx_s == cand_col_q)) begin
            if ((db_cnt_q + DW'(1)) == DB_TARGET) begin
              accept_s  = 1'b1;
              state_d   = HELD;
              db_cnt_d  = {DW{1'b0}};
              rel_cnt_d = {DW{1'b0}};
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_d = {RW{1'b0}};
`endif
            end else begin
              db_cnt_d = db_cnt_q + DW'(1);
            end
          end else begin
            state_d   = SCAN;
            db_cnt_d  = {DW{1'b0}};
            advance_s = 1'b1;
          end
        end
        HELD: begin
          if (col_s_q == 4'b1111) begin
            if ((rel_cnt_q + DW'(1)) == DB_TARGET) begin
              state_d   = SCAN;
              rel_cnt_d = {DW{1'b0}};
              advance_s = 1'b1;
            end else begin
              rel_cnt_d = rel_cnt_q + DW'(1);
            end
          end else begin
            rel_cnt_d = {DW{1'b0}};
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          // Row is held here, so a matching column means the same key code
          if (sample_valid_s && (col_idx_s == cand_col_q)) begin
            if ((rep_cnt_q + RW'(1)) == REP_TARGET) begin
              accept_s  = 1'b1;
              rep_cnt_d = {RW{1'b0}};
            end else begin
              rep_cnt_d = rep_cnt_q + RW'(1);
            end
          end else begin
            rep_cnt_d = {RW{1'b0}};
          end
`endif
        end
        default: begin
          state_d   = SCAN;
          db_cnt_d  = {DW{1'b0}};
          rel_cnt_d = {DW{1'b0}};
          advance_s = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output logic: row rotation, entry shift register, key code and valid pulse
  always_comb begin
    key_valid_d = accept_s;
    if (advance_s) begin
      row_idx_d = row_idx_q + 2'd1;
      row_d     = ~(4'b0001 << row_idx_d);
    end else begin
      row_idx_d = row_idx_q;
      row_d     = row_q;
    end
    if (accept_s) begin
      key_code_d = code_s;
      if (clear) begin
        data_d = {28'h000_0000, code_s};
      end else begin
        data_d = {data_q[27:0], code_s};
      end
    end else begin
      key_code_d = key_code_q;
      if (clear) begin
        data_d = 32'h0000_0000;
      end else begin
        data_d = data_q;
      end
    end
  end

  assign row       = row_q;
  assign data      = data_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: table of key presses, scoreboard on key_valid pulses, corner sequences.
module tb_keypad_entry;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int RS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [31:0] data;
  logic [3:0]  key_code;
  logic        key_valid;

  logic        press_en;
  logic [1:0]  press_row;
  logic [1:0]  press_col;
  logic        ghost_en;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t vec[11];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pulses = 0;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RS)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .clear(clear),
    .data(data), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: pressed key pulls its column low while its row is driven
  assign col = ghost_en ? 4'b1001 :
               (press_en && (row == ~(4'b0001 << press_row))) ? ~(4'b0001 << press_col) : 4'b1111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard: every key_valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (key_valid === 1'b1) begin
      n_pulses++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: key_code %h data %h, expected no pulse", key_code, data);
      end else begin
        e = sb_q.pop_front();
        check("pulse_key_code", {28'h0, key_code}, {28'h0, e.code});
        check("pulse_data", data, e.data);
      end
    end
  end

  task automatic wait_drain(input string name, input int max_cyc);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    check(name, sb_q.size(), 32'd0);
  endtask

  task automatic press_key(input logic [3:0] k);
    press_row = k[3:2];
    press_col = k[1:0];
    press_en  = 1'b1;
  endtask

  // Returns at the negedge right after row switches to the requested row
  task automatic sync_row(input logic [1:0] r);
    logic [3:0] tgt;
    int i;
    tgt = ~(4'b0001 << r);
    i = 0;
    while (row == tgt && i < 100) begin @(negedge clk); i++; end
    while (row != tgt && i < 200) begin @(negedge clk); i++; end
    check("sync_row", {28'h0, row}, {28'h0, tgt});
  endtask

  task automatic check_rotating(input string name);
    logic [3:0] r0;
    r0 = row;
    repeat (SD) @(negedge clk);
    check(name, {31'h0, (row != r0)}, 32'd1);
  endtask

  task automatic glitch_tests();
    logic [31:0] d0;
    int p0;
    d0 = data;
    p0 = n_pulses;
    sync_row(2'd1);
    press_key(4'h4);
    repeat (SD) @(negedge clk);
    check("bounce_row_held", {28'h0, row}, 32'h0000_000D);
    press_en = 1'b0;
    repeat (SD) @(negedge clk);
    check("bounce_row_next", {28'h0, row}, 32'h0000_000B);
    check("bounce_data", data, d0);
    ghost_en = 1'b1;
    repeat (6 * SD) @(negedge clk);
    check_rotating("ghost_row_rotates");
    ghost_en = 1'b0;
    repeat (2 * SD) @(negedge clk);
    check("glitch_no_pulse", n_pulses - p0, 32'd0);
    check("ghost_data", data, d0);
  endtask

  initial begin
    int p0;
    int c;
    rst = 1'b1; clear = 1'b0; press_en = 1'b0; ghost_en = 1'b0;
    press_row = 2'd0; press_col = 2'd0;

    vec[0]  = '{4'h6, 32'h0000_0006};
    vec[1]  = '{4'hF, 32'h0000_006F};
    vec[2]  = '{4'h1, 32'h0000_06F1};
    vec[3]  = '{4'h2, 32'h0000_6F12};
    vec[4]  = '{4'h3, 32'h0006_F123};
    vec[5]  = '{4'h4, 32'h006F_1234};
    vec[6]  = '{4'h5, 32'h06F1_2345};
    vec[7]  = '{4'h6, 32'h6F12_3456};
    vec[8]  = '{4'h7, 32'hF123_4567};
    vec[9]  = '{4'h8, 32'h1234_5678};
    vec[10] = '{4'h9, 32'h2345_6789};

    repeat (3) @(negedge clk);
    check("rst_row", {28'h0, row}, 32'h0000_000E);
    check("rst_data", data, 32'h0);
    check("rst_key_code", {28'h0, key_code}, 32'h0);
    check("rst_key_valid", {31'h0, key_valid}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    p0 = n_pulses;
    for (int i = 0; i < 11; i++) begin
      if (i == 2) begin
        glitch_tests();
        p0 = n_pulses;
      end
      sb_q.push_back(vec[i]);
      press_key(vec[i].code);
      wait_drain("key_accept", 200);
      press_en = 1'b0;
      repeat (30) @(negedge clk);
      check_rotating("row_rotates_after_release");
    end
    check("nine_key_pulses", n_pulses - p0, 32'd9);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_alone_data", data, 32'h0);
    check("clear_keeps_key_code", {28'h0, key_code}, 32'h0000_0009);

    sync_row(2'd2);
    press_key(4'hA);
    sb_q.push_back('{4'hA, 32'h0000_000A});
    repeat (2 * SD - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_drain("clear_with_accept", 2);
    press_en = 1'b0;
    repeat (30) @(negedge clk);

    sync_row(2'd1);
    press_key(4'h5);
    repeat (SD) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_row", {28'h0, row}, 32'h0000_000E);
    check("midrst_data", data, 32'h0);
    check("midrst_key_code", {28'h0, key_code}, 32'h0);
    check("midrst_key_valid", {31'h0, key_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_q.push_back('{4'h5, 32'h0000_0005});
    c = 0;
    while (sb_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("midrst_fresh_accept", sb_q.size(), 32'd0);
    check("midrst_full_debounce", {31'h0, (c >= DB * SD)}, 32'd1);
    press_en = 1'b0;
    repeat (30) @(negedge clk);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    p0 = n_pulses;
    sb_q.push_back('{4'h5, 32'h0000_0005});
`ifdef KEYPAD_AUTOREPEAT_EN
    sb_q.push_back('{4'h5, 32'h0000_0055});
    sb_q.push_back('{4'h5, 32'h0000_0555});
`endif
    press_key(4'h5);
    c = 0;
    while (n_pulses == p0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (26) @(negedge clk);
    press_en = 1'b0;
    repeat (40) @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("held_pulse_count", n_pulses - p0, 32'd3);
`else
    check("held_pulse_count", n_pulses - p0, 32'd1);
`endif
    check("held_scoreboard_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
